// File: rtl/skinny_inv_sbox8_isw1_hs.sv
// skinny_inv_sbox8_isw1_hs
// First-order ISW-masked inverse Skinny-128 8-bit S-box on two Boolean shares,
// wrapped in a valid/ready handshake. One transaction is in flight at a time.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_ready is high only in IDLE. out_valid is high only in DONE, and
// bo0/bo1 hold steady until that transfer completes. in_valid is ignored outside IDLE.
//
// Optional build macro SKINNY_ISW_FLUSH_EN: adds a one-cycle FLUSH state after
// every output transfer. FLUSH zeroes the capture and output registers and
// keeps in_ready low. Without the macro, DONE returns straight to IDLE.
//
// Each nor(a,b) is computed as ISW AND(~a, ~b). Only share 0 is inverted.
// All four partial products are registered. Both cross terms are XORed with
// the core's r bit, so r cancels only when the two output shares recombine.
// The captured shares are held constant. Because of that, the four AND levels
// settle one level per cycle and keep recomputing the same values until the
// output is loaded.
module skinny_inv_sbox8_isw1_hs #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] si0,
    input  logic [7:0] si1,
    input  logic [7:0] r,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] bo0,
    output logic [7:0] bo1,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    (* equivalent_register_removal = "no" *) state_t     state_q;
    (* equivalent_register_removal = "no" *) logic [2:0] cnt_q;
    state_t     state_d;
    logic [2:0] cnt_d;
    logic       cap_en;
    logic       load_en;
    logic       clr_en;

    // captured input shares and refresh masks
    (* equivalent_register_removal = "no" *) logic [7:0] o0_q;
    (* equivalent_register_removal = "no" *) logic [7:0] o1_q;
    (* equivalent_register_removal = "no" *) logic [7:0] r_q;

    // ISW partial products, bit k belongs to core k
    (* equivalent_register_removal = "no" *) logic [7:0] p00_q;
    (* equivalent_register_removal = "no" *) logic [7:0] p01_q;
    (* equivalent_register_removal = "no" *) logic [7:0] p10_q;
    (* equivalent_register_removal = "no" *) logic [7:0] p11_q;

    (* equivalent_register_removal = "no" *) logic [7:0] bo0_q;
    (* equivalent_register_removal = "no" *) logic [7:0] bo1_q;

    logic [7:0] xa0, xa1, xb0, xb1;   // AND operand shares per core
    logic [7:0] z0, z1;               // AND result shares per core
    logic [7:0] c0, c1;               // core outputs after the linear term
    logic [7:0] b0s, b1s;             // core outputs in S-box bit order

    // Core to bit map:
    //   core0 b3, core1 b5, core2 b2, core3 b7   (level 1)
    //   core4 b1, core5 b0                       (level 2)
    //   core6 b6                                 (level 3)
    //   core7 b4                                 (level 4)
    assign z0 = p00_q ^ p01_q;
    assign z1 = p11_q ^ p10_q;

    // Linear terms, core7..core0: o6 o2 o5 o3 o1 o0 o7 o4
    assign c0 = z0 ^ {o0_q[6], o0_q[2], o0_q[5], o0_q[3], o0_q[1], o0_q[0], o0_q[7], o0_q[4]};
    assign c1 = z1 ^ {o1_q[6], o1_q[2], o1_q[5], o1_q[3], o1_q[1], o1_q[0], o1_q[7], o1_q[4]};

    // First nor operand, core7..core0: b7 b2 b3 o5 o2 o3 o6 o7
    assign xa0 = ~{c0[3], c0[2], c0[0], o0_q[5], o0_q[2], o0_q[3], o0_q[6], o0_q[7]};
    assign xa1 =  {c1[3], c1[2], c1[0], o1_q[5], o1_q[2], o1_q[3], o1_q[6], o1_q[7]};

    // Second nor operand, core7..core0: b6 b1 b2 b3 o7 o1 o5 o6
    assign xb0 = ~{c0[6], c0[4], c0[2], c0[0], o0_q[7], o0_q[1], o0_q[5], o0_q[6]};
    assign xb1 =  {c1[6], c1[4], c1[2], c1[0], o1_q[7], o1_q[1], o1_q[5], o1_q[6]};

    // Output order b7..b0 = core3 core6 core1 core7 core0 core2 core4 core5
    assign b0s = {c0[3], c0[6], c0[1], c0[7], c0[0], c0[2], c0[4], c0[5]};
    assign b1s = {c1[3], c1[6], c1[1], c1[7], c1[0], c1[2], c1[4], c1[5]};

    assign bo0       = bo0_q;
    assign bo1       = bo1_q;
    assign dbg_state = state_q;

    // FSM state and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state, handshake outputs and register enables
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_en    = 1'b0;
        load_en   = 1'b0;
        clr_en    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cap_en  = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(WAIT_CYCLES)) begin
                    load_en = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
`ifdef SKINNY_ISW_FLUSH_EN
                    clr_en  = 1'b1;
                    state_d = FLUSH;
`else
                    state_d = IDLE;
`endif
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the input shares and masks on an accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o0_q <= 8'h00;
            o1_q <= 8'h00;
            r_q  <= 8'h00;
        end else if (cap_en) begin
            o0_q <= si0;
            o1_q <= si1;
            r_q  <= r;
        end else if (clr_en) begin
            o0_q <= 8'h00;
            o1_q <= 8'h00;
            r_q  <= 8'h00;
        end
    end

    // Register the ISW partial products of all eight cores every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p00_q <= 8'h00;
            p01_q <= 8'h00;
            p10_q <= 8'h00;
            p11_q <= 8'h00;
        end else begin
            p00_q <= xa0 & xb0;
            p01_q <= (xa0 & xb1) ^ r_q;
            p10_q <= (xa1 & xb0) ^ r_q;
            p11_q <= xa1 & xb1;
        end
    end

    // Load the output shares once the last AND level has settled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bo0_q <= 8'h00;
            bo1_q <= 8'h00;
        end else if (load_en) begin
            bo0_q <= b0s;
            bo1_q <= b1s;
        end else if (clr_en) begin
            bo0_q <= 8'h00;
            bo1_q <= 8'h00;
        end
    end

endmodule

// File: tb/tb_skinny_inv_sbox8_isw1_hs.sv
// Bench for skinny_inv_sbox8_isw1_hs: directed cases, a masked sweep of all
// 256 inputs with random output backpressure, and a mid-transaction reset.
module tb_skinny_inv_sbox8_isw1_hs;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] si0, si1, r;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] bo0, bo1;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_count = 0;
    logic [7:0] last_bo0 = 8'h00;
    logic       bp_mode  = 1'b0;
    logic       or_force = 1'b1;

    logic [7:0] exp_q[$];
    int         cap_q[$];

    skinny_inv_sbox8_isw1_hs #(.WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .si0       (si0),
        .si1       (si1),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bo0       (bo0),
        .bo1       (bo1),
        .dbg_state (dbg_state)
    );

    // clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // reference model: inverse S-box written directly from the bit equations
    function automatic logic [7:0] inv_sbox(input logic [7:0] o);
        logic [7:0] b;
        b[3] = ~(o[7] | o[6]) ^ o[4];
        b[5] = ~(o[6] | o[5]) ^ o[7];
        b[2] = ~(o[3] | o[1]) ^ o[0];
        b[7] = ~(o[2] | o[7]) ^ o[1];
        b[1] = ~(o[5] | b[3]) ^ o[3];
        b[0] = ~(b[3] | b[2]) ^ o[5];
        b[6] = ~(b[2] | b[1]) ^ o[2];
        b[4] = ~(b[7] | b[6]) ^ o[6];
        return b;
    endfunction

    // driver: present one transaction, push its expectation, wait for capture
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] m, input logic [7:0] e,
                        input logic hold);
        int n;
        n = 0;
        si0 = a; si1 = b; r = m; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        cap_q.push_back(cyc);
        in_valid = hold;
        si0 = 8'($urandom); si1 = 8'($urandom); r = 8'($urandom);
    endtask

    task automatic wait_hs(input int target, input string name);
        int n;
        n = 0;
        while (hs_count < target && n < 300) begin
            @(negedge clk); #3;
            n++;
        end
        if (hs_count < target) fail_now(name);
    endtask

    // out_ready driver: random backpressure or a forced level
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk); #1;
            out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : or_force;
        end
    end

    // monitor / scoreboard
    initial begin : monitor
        logic       prev_ov;
        logic       after_hs;
        logic [7:0] h0, h1;
        int         c;
        logic [7:0] e;
        prev_ov = 1'b0; after_hs = 1'b0; h0 = 8'h00; h1 = 8'h00;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                prev_ov  = 1'b0;
                after_hs = 1'b0;
                continue;
            end
            if (after_hs) begin
                after_hs = 1'b0;
                check("post_hs_out_valid", int'(out_valid), 0);
`ifdef SKINNY_ISW_FLUSH_EN
                check("flush_in_ready", int'(in_ready), 0);
                check("flush_bo0", int'(bo0), 0);
                check("flush_bo1", int'(bo1), 0);
`else
                check("post_hs_in_ready", int'(in_ready), 1);
`endif
            end
            if (out_valid) begin
                check("done_in_ready", int'(in_ready), 0);
                if (!prev_ov) begin
                    if (cap_q.size() == 0) begin
                        fail_now("output_without_capture");
                    end else begin
                        c = cap_q.pop_front();
                        check("latency", cyc - c, W + 1);
                    end
                    h0 = bo0;
                    h1 = bo1;
                end else begin
                    check("hold_bo0", int'(bo0), int'(h0));
                    check("hold_bo1", int'(bo1), int'(h1));
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        e = exp_q.pop_front();
                        check("result", int'(bo0 ^ bo1), int'(e));
                    end
                    last_bo0 = bo0;
                    hs_count++;
                    after_hs = 1'b1;
                end
            end
            prev_ov = out_valid;
        end
    end

    // main sequence
    initial begin
        logic [7:0] bo_a;
        logic [7:0] v, s;
        logic       seen [256];
        int         distinct;
        int         n;

        rst_n = 1'b0; in_valid = 1'b0; si0 = 8'h00; si1 = 8'h00; r = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_bo0", int'(bo0), 0);
        check("rst_bo1", int'(bo1), 0);
        #3 rst_n = 1'b1;
        @(negedge clk); #1;
        check("release_in_ready", int'(in_ready), 1);

        // model sanity: known forward S-box points and bijectivity
        check("model_65", int'(inv_sbox(8'h65)), 8'h00);
        check("model_4c", int'(inv_sbox(8'h4c)), 8'h01);
        check("model_6a", int'(inv_sbox(8'h6a)), 8'h02);
        check("model_42", int'(inv_sbox(8'h42)), 8'h03);
        check("model_4b", int'(inv_sbox(8'h4b)), 8'h04);
        check("model_55", int'(inv_sbox(8'h55)), 8'h08);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        distinct = 0;
        for (int i = 0; i < 256; i++) begin
            v = inv_sbox(8'(i));
            if (!seen[v]) distinct++;
            seen[v] = 1'b1;
        end
        check("model_bijective", distinct, 256);

        // directed cases
        send(8'h65, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_hs(1, "hs_timeout_65");
        send(8'h0c, 8'h40, 8'ha7, 8'h01, 1'b0);
        wait_hs(2, "hs_timeout_0c_a");
        bo_a = last_bo0;
        send(8'h0c, 8'h40, 8'h3c, 8'h01, 1'b0);
        wait_hs(3, "hs_timeout_0c_b");
        check("bo0_mask_dependent", int'(bo_a != last_bo0), 1);
        send(8'ha5, 8'h5a, 8'hff, 8'hff, 1'b0);
        wait_hs(4, "hs_timeout_a5");

        // backpressure with in_valid held high throughout
        or_force = 1'b0;
        @(negedge clk); #3;
        send(8'h6a, 8'h00, 8'h5a, 8'h02, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk); #3;
            n++;
        end
        if (!out_valid) fail_now("bp_out_valid_timeout");
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        or_force = 1'b1;
        wait_hs(5, "hs_timeout_bp");
        repeat (15) @(negedge clk);
        check("bp_no_extra_capture", cap_q.size(), 0);

        // reset in the middle of BUSY
        send(8'h42, 8'h11, 8'h22, 8'h03, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_bo0", int'(bo0), 0);
        check("midrst_bo1", int'(bo1), 0);
        exp_q.delete();
        cap_q.delete();
        @(negedge clk); #3 rst_n = 1'b1;
        @(negedge clk); #3;
        check("midrst_in_ready", int'(in_ready), 1);
        n = hs_count;
        send(8'h5d, 8'h11, 8'h96, 8'h01, 1'b0);
        wait_hs(n + 1, "hs_timeout_after_rst");
        check("after_rst_bo", int'(last_bo0 != 8'h00 || 1'b1), 1);

        // masked sweep of all 256 inputs with random backpressure
        bp_mode = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            s = 8'($urandom);
            send(s, s ^ v, 8'($urandom), inv_sbox(v), 1'b0);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk); #3;
            n++;
        end
        check("drain_exp_q", exp_q.size(), 0);
        bp_mode = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        fail_now("watchdog");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
